// File: rtl/dc_bsp_pkg.sv
// rtl/dc_bsp_pkg.sv - BSP interrupt line order and IRQ CSR register map.
package dc_bsp_pkg;

  localparam int BSP_NUM_INTERRUPT_LINES = 4;

  // Line order of the interrupt sources on irq_in
  localparam int BSP_DMA_0_IRQ_BIT  = 0;
  localparam int BSP_KERNEL_IRQ_BIT = 1;
  localparam int BSP_DMA_1_IRQ_BIT  = 2;
  localparam int BSP_SPARE_IRQ_BIT  = 3;

  localparam int BSP_IRQ_CSR_STATUS     = 0;
  localparam int BSP_IRQ_CSR_MASK       = 1;
  localparam int BSP_IRQ_CSR_CLEAR      = 2;
  localparam int BSP_IRQ_CSR_RAW        = 3;
  localparam int BSP_IRQ_CSR_ID         = 4;
  localparam int BSP_IRQ_CSR_COUNT_BASE = 8;

  localparam logic [63:0] BSP_IRQ_CSR_ID_VALUE = 64'h1A5C_0001;

endpackage

// File: rtl/bsp_irq_line.sv
// rtl/bsp_irq_line.sv - edge detect, pending bit and optional event counter for one IRQ line.
// Counter built only when BSP_IRQ_CSR_COUNTER_EN is defined.
module bsp_irq_line #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_irq,
  input  logic             i_clr,
  input  logic             i_cnt_clr,
  output logic             o_pending,
  output logic             o_prev,
  output logic [CNT_W-1:0] o_count
);

  logic r_prev;
  logic r_pending;
  logic w_set;

  assign w_set = i_irq & ~r_prev;

  // A new edge beats a same-cycle clear so no event is lost
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_prev    <= i_irq;
      r_pending <= w_set | (r_pending & ~i_clr);
    end
  end

  assign o_pending = r_pending;
  assign o_prev    = r_prev;

`ifdef BSP_IRQ_CSR_COUNTER_EN
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_cnt_clr) begin
      r_count <= '0;
    end else if (w_set && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = i_cnt_clr;
  assign o_count          = '0;
`endif

endmodule

// File: rtl/bsp_irq_csr_responder.sv
// rtl/bsp_irq_csr_responder.sv - AVMM CSR responder collecting BSP IRQ lines into one host IRQ.
// Optional per-line event counters at words 8+i under BSP_IRQ_CSR_COUNTER_EN.
module bsp_irq_csr_responder
  import dc_bsp_pkg::*;
#(
  parameter int NUM_IRQ    = BSP_NUM_INTERRUPT_LINES,
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 4,
  parameter int RD_LATENCY = 2,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic [ADDR_W-1:0]   avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [DATA_W-1:0]   avs_writedata,
  input  logic [DATA_W/8-1:0] avs_byteenable,
  output logic                avs_waitrequest,
  output logic [DATA_W-1:0]   avs_readdata,
  output logic                avs_readdatavalid,
  output logic                irq_out
);

  logic                r_waitreq;
  logic                r_irq_out;
  logic [NUM_IRQ-1:0]  r_mask;
  logic [NUM_IRQ-1:0]  w_pending;
  logic [NUM_IRQ-1:0]  w_prev;
  logic [NUM_IRQ-1:0]  w_clr;
  logic [NUM_IRQ-1:0]  w_cnt_clr;
  logic [CNT_W-1:0]    w_count [NUM_IRQ];
  logic                w_rd_acc;
  logic                w_wr_acc;
  logic                w_lane0;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_unused_wr_bits;

  assign w_rd_acc         = avs_read & ~r_waitreq;
  assign w_wr_acc         = avs_write & ~r_waitreq;
  assign w_lane0          = avs_byteenable[0];
  assign w_unused_wr_bits = ^{avs_byteenable, avs_writedata};

  assign w_clr = (w_wr_acc && w_lane0 && (avs_address == ADDR_W'(BSP_IRQ_CSR_CLEAR)))
                 ? avs_writedata[NUM_IRQ-1:0] : '0;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
    assign w_cnt_clr[g] = w_wr_acc && (avs_address == ADDR_W'(BSP_IRQ_CSR_COUNT_BASE + g));

    bsp_irq_line #(.CNT_W(CNT_W)) u_line (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_irq     (irq_in[g]),
      .i_clr     (w_clr[g]),
      .i_cnt_clr (w_cnt_clr[g]),
      .o_pending (w_pending[g]),
      .o_prev    (w_prev[g]),
      .o_count   (w_count[g])
    );
  end

  // Read data reflects state before any same-cycle write
  always_comb begin
    w_rdata = '0;
    case (avs_address)
      ADDR_W'(BSP_IRQ_CSR_STATUS): w_rdata = DATA_W'(w_pending);
      ADDR_W'(BSP_IRQ_CSR_MASK):   w_rdata = DATA_W'(r_mask);
      ADDR_W'(BSP_IRQ_CSR_RAW):    w_rdata = DATA_W'(w_prev);
      ADDR_W'(BSP_IRQ_CSR_ID):     w_rdata = DATA_W'(BSP_IRQ_CSR_ID_VALUE);
      default:                     w_rdata = '0;
    endcase
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (avs_address == ADDR_W'(BSP_IRQ_CSR_COUNT_BASE + i)) begin
        w_rdata = DATA_W'(w_count[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_waitreq <= 1'b1;
      r_mask    <= '0;
      r_irq_out <= 1'b0;
    end else begin
      r_waitreq <= 1'b0;
      r_irq_out <= |(w_pending & r_mask);
      if (w_wr_acc && w_lane0 && (avs_address == ADDR_W'(BSP_IRQ_CSR_MASK))) begin
        r_mask <= avs_writedata[NUM_IRQ-1:0];
      end
    end
  end

  logic [RD_LATENCY-1:0] r_rd_vld;
  logic [DATA_W-1:0]     r_rd_dat [RD_LATENCY];

  // Data stages only load with a valid beat, so the last stage holds between responses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_rd_dat[i] <= '0;
      end
    end else begin
      r_rd_vld[0] <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_dat[0] <= w_rdata;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_rd_vld[i] <= r_rd_vld[i-1];
        if (r_rd_vld[i-1]) begin
          r_rd_dat[i] <= r_rd_dat[i-1];
        end
      end
    end
  end

  assign avs_waitrequest   = r_waitreq;
  assign avs_readdata      = r_rd_dat[RD_LATENCY-1];
  assign avs_readdatavalid = r_rd_vld[RD_LATENCY-1];
  assign irq_out           = r_irq_out;

endmodule

// File: tb/tb_bsp_irq_csr_responder.sv
// tb/tb_bsp_irq_csr_responder.sv - self-checking bench for bsp_irq_csr_responder.
module tb_bsp_irq_csr_responder;
  import dc_bsp_pkg::*;

  localparam int NI = 4;
  localparam int DW = 64;
  localparam int AW = 4;
  localparam int RL = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NI-1:0] irq_in = '0;
  logic [AW-1:0] avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [DW-1:0] avs_writedata = '0;
  logic [DW/8-1:0] avs_byteenable = '0;
  logic          avs_waitrequest;
  logic [DW-1:0] avs_readdata;
  logic          avs_readdatavalid;
  logic          irq_out;

  bsp_irq_csr_responder #(
    .NUM_IRQ(NI), .DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(RL), .CNT_W(CW)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .irq_in            (irq_in),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .irq_out           (irq_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [7:0]    be;
    logic [DW-1:0] e;
  } vec_t;
  vec_t tv[14];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (avs_readdatavalid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rdv_unexpected: readdatavalid=1 at cycle %0d, required 0", cyc);
      end else begin
        e = sb.pop_front();
        check("rd_data", avs_readdata, e.data);
        check("rd_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic rd(input int a, input logic [DW-1:0] exp);
    @(negedge clk);
    avs_read = 1'b1;
    avs_write = 1'b0;
    avs_address = AW'(a);
    sb.push_back('{exp, cyc + RL});
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input logic [7:0] be);
    @(negedge clk);
    avs_write = 1'b1;
    avs_read = 1'b0;
    avs_address = AW'(a);
    avs_writedata = d;
    avs_byteenable = be;
  endtask

  task automatic idle();
    @(negedge clk);
    avs_read = 1'b0;
    avs_write = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d reads outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{1'b1, AW'(BSP_IRQ_CSR_MASK),   64'h5,   8'h01, 64'h0};
    tv[1]  = '{1'b0, AW'(BSP_IRQ_CSR_MASK),   64'h0,   8'h00, 64'h5};
    tv[2]  = '{1'b1, AW'(BSP_IRQ_CSR_MASK),   64'hA,   8'hFE, 64'h0};
    tv[3]  = '{1'b0, AW'(BSP_IRQ_CSR_MASK),   64'h0,   8'h00, 64'h5};
    tv[4]  = '{1'b1, AW'(BSP_IRQ_CSR_MASK),   64'hFF,  8'hFF, 64'h0};
    tv[5]  = '{1'b0, AW'(BSP_IRQ_CSR_MASK),   64'h0,   8'h00, 64'hF};
    tv[6]  = '{1'b1, AW'(BSP_IRQ_CSR_ID),     64'h123, 8'hFF, 64'h0};
    tv[7]  = '{1'b0, AW'(BSP_IRQ_CSR_ID),     64'h0,   8'h00, 64'h1A5C_0001};
    tv[8]  = '{1'b0, AW'(5),                  64'h0,   8'h00, 64'h0};
    tv[9]  = '{1'b0, AW'(BSP_IRQ_CSR_STATUS), 64'h0,   8'h00, 64'h0};
    tv[10] = '{1'b0, AW'(BSP_IRQ_CSR_RAW),    64'h0,   8'h00, 64'h0};
    tv[11] = '{1'b0, AW'(11),                 64'h0,   8'h00, 64'h0};
    tv[12] = '{1'b1, AW'(BSP_IRQ_CSR_MASK),   64'h0,   8'h01, 64'h0};
    tv[13] = '{1'b0, AW'(BSP_IRQ_CSR_MASK),   64'h0,   8'h00, 64'h0};

    repeat (2) @(negedge clk);
    check("rst_waitrequest", 64'(avs_waitrequest), 64'h1);
    check("rst_rdv", 64'(avs_readdatavalid), 64'h0);
    check("rst_readdata", avs_readdata, 64'h0);
    check("rst_irq_out", 64'(irq_out), 64'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check("waitrequest_release", 64'(avs_waitrequest), 64'h0);

    for (int i = 0; i < 14; i++) begin
      if (tv[i].w) wr(int'(tv[i].a), tv[i].d, tv[i].be);
      else rd(int'(tv[i].a), tv[i].e);
      idle();
    end
    drain();

    // Masked kernel pulse, then unmask
    @(negedge clk); irq_in[BSP_KERNEL_IRQ_BIT] = 1'b1;
    @(negedge clk); irq_in[BSP_KERNEL_IRQ_BIT] = 1'b0;
    repeat (2) @(negedge clk);
    check("masked_irq_out", 64'(irq_out), 64'h0);
    rd(BSP_IRQ_CSR_STATUS, 64'h2);
    idle();
    wr(BSP_IRQ_CSR_MASK, 64'h2, 8'h01);
    idle();
    check("irq_out_1cyc", 64'(irq_out), 64'h0);
    @(negedge clk);
    check("irq_out_2cyc", 64'(irq_out), 64'h1);
    wr(BSP_IRQ_CSR_CLEAR, 64'h2, 8'h01);
    idle();
    wr(BSP_IRQ_CSR_MASK, 64'h0, 8'h01);
    idle();
    drain();

    // Held level: one pending set, clear sticks while still high
    @(negedge clk); irq_in[BSP_DMA_0_IRQ_BIT] = 1'b1;
    rd(BSP_IRQ_CSR_STATUS, 64'h1);
    rd(BSP_IRQ_CSR_RAW, 64'h1);
    idle();
    wr(BSP_IRQ_CSR_CLEAR, 64'h1, 8'h01);
    idle();
    rd(BSP_IRQ_CSR_STATUS, 64'h0);
    idle();
    repeat (2) @(negedge clk);
    rd(BSP_IRQ_CSR_STATUS, 64'h0);
    idle();
    @(negedge clk); irq_in[BSP_DMA_0_IRQ_BIT] = 1'b0;
    drain();

    // Rising edge and CLEAR in the same cycle: set wins
    @(negedge clk); irq_in[BSP_DMA_1_IRQ_BIT] = 1'b1;
    @(negedge clk); irq_in[BSP_DMA_1_IRQ_BIT] = 1'b0;
    wr(BSP_IRQ_CSR_CLEAR, 64'h4, 8'h01);
    irq_in[BSP_DMA_1_IRQ_BIT] = 1'b1;
    idle();
    rd(BSP_IRQ_CSR_STATUS, 64'h4);
    idle();
    wr(BSP_IRQ_CSR_CLEAR, 64'h4, 8'h01);
    idle();
    rd(BSP_IRQ_CSR_STATUS, 64'h0);
    idle();
    @(negedge clk); irq_in[BSP_DMA_1_IRQ_BIT] = 1'b0;
    drain();

    // Back-to-back reads
    @(negedge clk); irq_in[BSP_SPARE_IRQ_BIT] = 1'b1;
    @(negedge clk); irq_in[BSP_SPARE_IRQ_BIT] = 1'b0;
    wr(BSP_IRQ_CSR_MASK, 64'h9, 8'h01);
    idle();
    rd(BSP_IRQ_CSR_ID, 64'h1A5C_0001);
    rd(BSP_IRQ_CSR_STATUS, 64'h8);
    rd(BSP_IRQ_CSR_MASK, 64'h9);
    rd(7, 64'h0);
    idle();
    check("irq_out_masked_on", 64'(irq_out), 64'h1);
    drain();

    // Read and write in one cycle returns the pre-write value
    @(negedge clk);
    avs_read = 1'b1;
    avs_write = 1'b1;
    avs_address = AW'(BSP_IRQ_CSR_MASK);
    avs_writedata = 64'h3;
    avs_byteenable = 8'h01;
    sb.push_back('{64'h9, cyc + RL});
    idle();
    rd(BSP_IRQ_CSR_MASK, 64'h3);
    idle();
    drain();

`ifdef BSP_IRQ_CSR_COUNTER_EN
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); irq_in[BSP_SPARE_IRQ_BIT] = 1'b1;
      @(negedge clk); irq_in[BSP_SPARE_IRQ_BIT] = 1'b0;
    end
    rd(BSP_IRQ_CSR_COUNT_BASE + 3, 64'hF);
    idle();
    wr(BSP_IRQ_CSR_COUNT_BASE + 3, 64'h0, 8'h01);
    idle();
    rd(BSP_IRQ_CSR_COUNT_BASE + 3, 64'h0);
    idle();
    wr(BSP_IRQ_CSR_COUNT_BASE + 3, 64'h0, 8'h00);
    irq_in[BSP_SPARE_IRQ_BIT] = 1'b1;
    idle();
    irq_in[BSP_SPARE_IRQ_BIT] = 1'b0;
    rd(BSP_IRQ_CSR_COUNT_BASE + 3, 64'h0);
    idle();
    drain();
`endif

    // Reset with two reads in flight
    wr(BSP_IRQ_CSR_MASK, 64'hF, 8'h01);
    idle();
    @(negedge clk);
    check("irq_out_pre_reset", 64'(irq_out), 64'h1);
    avs_read = 1'b1;
    avs_address = AW'(BSP_IRQ_CSR_STATUS);
    @(negedge clk);
    avs_address = AW'(BSP_IRQ_CSR_MASK);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    avs_read = 1'b0;
    @(negedge clk);
    check("midrd_waitrequest", 64'(avs_waitrequest), 64'h1);
    check("midrd_rdv", 64'(avs_readdatavalid), 64'h0);
    check("midrd_readdata", avs_readdata, 64'h0);
    check("midrd_irq_out", 64'(irq_out), 64'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_waitrequest", 64'(avs_waitrequest), 64'h0);
    rd(BSP_IRQ_CSR_STATUS, 64'h0);
    rd(BSP_IRQ_CSR_MASK, 64'h0);
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
